// File: rtl/rc5_sched.sv
// rc5_sched: round-robin scheduler for two clients sharing one RC5 round datapath.
// Issues one job at a time, waits for the result or a timeout, and buffers it per client.
module rc5_sched #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic        i_req0_flag,
  input  logic [63:0] i_req0_din,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic        i_req1_flag,
  input  logic [63:0] i_req1_din,
  output logic        o_res0_valid,
  input  logic        i_res0_ready,
  output logic [63:0] o_res0_dout,
  output logic        o_res0_err,
  output logic        o_res1_valid,
  input  logic        i_res1_ready,
  output logic [63:0] o_res1_dout,
  output logic        o_res1_err,
  output logic        o_core_rst,
  output logic        o_core_flag,
  output logic [63:0] o_core_din,
  output logic        o_core_din_en,
  input  logic [63:0] i_core_dout,
  input  logic        i_core_dout_en,
  output logic        o_busy,
  output logic [15:0] o_job_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state, state_nxt;
  logic        last;
  logic        owner;
  logic        elig0, elig1;
  logic        grant, grant_vld;
  logic        accept;
  logic        done_ok, done_to, done;
  logic [63:0] res_data;
  logic [7:0]  wdog;
  logic [15:0] job_cnt;

  // A client holding an unread result is not eligible, so a buffer is never overwritten.
  assign elig0     = i_req0_valid & ~o_res0_valid;
  assign elig1     = i_req1_valid & ~o_res1_valid;
  assign grant_vld = elig0 | elig1;
  assign grant     = (elig0 & elig1) ? ~last : elig1;

  assign o_req0_ready = i_rst_n & (state == IDLE) & grant_vld & ~grant;
  assign o_req1_ready = i_rst_n & (state == IDLE) & grant_vld & grant;
  assign accept       = (o_req0_ready & i_req0_valid) | (o_req1_ready & i_req1_valid);

  assign done_ok  = (state == WAIT) & i_core_dout_en;
  assign done_to  = (state == WAIT) & ~i_core_dout_en & (wdog == 8'(TIMEOUT - 1));
  assign done     = done_ok | done_to;
  assign res_data = done_ok ? i_core_dout : 64'h0;

  assign o_core_rst = ~i_rst_n;
  assign o_busy     = (state != IDLE);
  assign o_job_cnt  = job_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last          <= 1'b1;
      owner         <= 1'b0;
      wdog          <= 8'd0;
      job_cnt       <= 16'd0;
      o_core_flag   <= 1'b0;
      o_core_din    <= 64'h0;
      o_core_din_en <= 1'b0;
      o_res0_valid  <= 1'b0;
      o_res0_err    <= 1'b0;
      o_res0_dout   <= 64'h0;
      o_res1_valid  <= 1'b0;
      o_res1_err    <= 1'b0;
      o_res1_dout   <= 64'h0;
    end else begin
      o_core_din_en <= accept;
      if (accept) begin
        owner       <= grant;
        last        <= grant;
        o_core_flag <= grant ? i_req1_flag : i_req0_flag;
        o_core_din  <= grant ? i_req1_din : i_req0_din;
      end

      if (state == ISSUE)     wdog <= 8'd0;
      else if (state == WAIT) wdog <= wdog + 8'd1;

      if (o_res0_valid && i_res0_ready) o_res0_valid <= 1'b0;
      if (o_res1_valid && i_res1_ready) o_res1_valid <= 1'b0;

      // Completion only targets the owner, whose buffer is known to be empty.
      if (done) begin
        job_cnt <= job_cnt + 16'd1;
        if (owner) begin
          o_res1_valid <= 1'b1;
          o_res1_err   <= done_to;
          o_res1_dout  <= res_data;
        end else begin
          o_res0_valid <= 1'b1;
          o_res0_err   <= done_to;
          o_res0_dout  <= res_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_rc5_sched.sv
// Self-checking bench for rc5_sched: cycle-level transaction model plus directed scenarios
// and a randomized phase, with a behavioural 11-cycle datapath responder.
module tb_rc5_sched;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_flag, req1_valid, req1_flag;
  logic [63:0] req0_din, req1_din;
  logic        res0_ready, res1_ready;
  logic [63:0] core_dout;
  logic        core_dout_en;

  logic        req0_ready, req1_ready;
  logic        res0_valid, res0_err, res1_valid, res1_err;
  logic [63:0] res0_dout, res1_dout;
  logic        core_rst, core_flag, core_din_en, busy;
  logic [63:0] core_din;
  logic [15:0] job_cnt;

  always #5 clk = ~clk;

  rc5_sched #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_flag(req0_flag), .i_req0_din(req0_din),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_flag(req1_flag), .i_req1_din(req1_din),
    .o_res0_valid(res0_valid), .i_res0_ready(res0_ready),
    .o_res0_dout(res0_dout), .o_res0_err(res0_err),
    .o_res1_valid(res1_valid), .i_res1_ready(res1_ready),
    .o_res1_dout(res1_dout), .o_res1_err(res1_err),
    .o_core_rst(core_rst), .o_core_flag(core_flag), .o_core_din(core_din),
    .o_core_din_en(core_din_en), .i_core_dout(core_dout), .i_core_dout_en(core_dout_en),
    .o_busy(busy), .o_job_cnt(job_cnt)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  // Transaction-level model: a job is described by its accept cycle and owner.
  bit          m_active;
  int          m_start;
  bit          m_owner;
  bit          m_last;
  bit          m_flag;
  logic [63:0] m_din;
  bit   [1:0]  m_rv;
  bit   [1:0]  m_re;
  logic [63:0] m_rd [2];
  logic [15:0] m_cnt;

  int acc_cyc[$];
  int acc_cli[$];
  int res_cyc[$];
  int res_err_q[$];

  // Datapath responder controls.
  bit          dp_on    = 1;
  bit          dp_const = 0;
  bit          stray_rand = 0;
  int          stray_cyc = -1;
  int          dp_t[$];
  logic [63:0] dp_d[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] dp_func(input logic [63:0] din, input logic flag);
    if (dp_const) return 64'hDEADBEEF00000001;
    return {din[31:0], din[63:32]} ^ (flag ? 64'hA5A5_0F0F_5A5A_F0F0 : 64'h3C3C_C3C3_1234_8765);
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_last   = 1;
    m_flag   = 0;
    m_din    = 64'h0;
    m_rv     = 2'b00;
    m_re     = 2'b00;
    m_rd[0]  = 64'h0;
    m_rd[1]  = 64'h0;
    m_cnt    = 16'h0;
  endtask

  task automatic model_finish(input logic [63:0] d, input bit err);
    m_rv[m_owner] = 1;
    m_re[m_owner] = err;
    m_rd[m_owner] = d;
    m_cnt         = m_cnt + 16'd1;
    m_active      = 0;
    res_cyc.push_back(cyc + 1);
    res_err_q.push_back(int'(err));
  endtask

  // One clock: compare at the falling edge, advance the model, then drive the datapath.
  task automatic tick();
    bit e0, e1, er0, er1, acc0, acc1;
    @(negedge clk);
    er0 = 0;
    er1 = 0;
    if (rst_n && !m_active) begin
      e0 = req0_valid && !m_rv[0];
      e1 = req1_valid && !m_rv[1];
      if (e0 && e1) begin
        er0 = m_last;
        er1 = !m_last;
      end else begin
        er0 = e0;
        er1 = e1;
      end
    end
    if (chk_en) begin
      checkOutput("req0_ready", 64'(req0_ready), 64'(er0));
      checkOutput("req1_ready", 64'(req1_ready), 64'(er1));
      checkOutput("core_rst", 64'(core_rst), 64'(!rst_n));
      checkOutput("busy", 64'(busy), 64'(m_active));
      checkOutput("din_en", 64'(core_din_en), 64'(m_active && (cyc == m_start + 1)));
      checkOutput("core_flag", 64'(core_flag), 64'(m_flag));
      checkOutput("core_din", core_din, m_din);
      checkOutput("res0_valid", 64'(res0_valid), 64'(m_rv[0]));
      checkOutput("res1_valid", 64'(res1_valid), 64'(m_rv[1]));
      checkOutput("res0_err", 64'(res0_err), 64'(m_re[0]));
      checkOutput("res1_err", 64'(res1_err), 64'(m_re[1]));
      checkOutput("res0_dout", res0_dout, m_rd[0]);
      checkOutput("res1_dout", res1_dout, m_rd[1]);
      checkOutput("job_cnt", 64'(job_cnt), 64'(m_cnt));
    end
    acc0 = er0 && req0_valid;
    acc1 = er1 && req1_valid;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_rv[0] && res0_ready) m_rv[0] = 0;
      if (m_rv[1] && res1_ready) m_rv[1] = 0;
      if (m_active && cyc >= m_start + 2) begin
        if (core_dout_en)                     model_finish(core_dout, 0);
        else if (cyc == m_start + 1 + TIMEOUT) model_finish(64'h0, 1);
      end else if (acc0 || acc1) begin
        m_active = 1;
        m_start  = cyc;
        m_owner  = acc1;
        m_last   = acc1;
        m_flag   = acc1 ? req1_flag : req0_flag;
        m_din    = acc1 ? req1_din : req0_din;
        acc_cyc.push_back(cyc);
        acc_cli.push_back(int'(acc1));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      dp_t.delete();
      dp_d.delete();
    end else if (core_din_en && dp_on) begin
      dp_t.push_back(cyc + 11);
      dp_d.push_back(dp_func(core_din, core_flag));
    end
    while (dp_t.size() > 0 && dp_t[0] < cyc) begin
      void'(dp_t.pop_front());
      void'(dp_d.pop_front());
    end
    core_dout_en = 0;
    core_dout    = {$urandom, $urandom};
    if (dp_t.size() > 0 && dp_t[0] == cyc) begin
      core_dout_en = 1;
      core_dout    = dp_d[0];
      void'(dp_t.pop_front());
      void'(dp_d.pop_front());
    end else if (cyc == stray_cyc || (stray_rand && $urandom_range(0, 49) == 0)) begin
      core_dout_en = 1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_accept(input string tag);
    int n0;
    int budget;
    n0 = acc_cyc.size();
    budget = 0;
    while (acc_cyc.size() == n0 && budget < 80) begin
      tick();
      budget++;
    end
    checkOutput(tag, 64'(acc_cyc.size() > n0), 64'd1);
  endtask

  task automatic applyStimulus();
    rst_n      = ($urandom_range(0, 399) != 0);
    req0_valid = ($urandom_range(0, 9) < 6);
    req1_valid = ($urandom_range(0, 9) < 6);
    req0_flag  = 1'($urandom_range(0, 1));
    req1_flag  = 1'($urandom_range(0, 1));
    req0_din   = {$urandom, $urandom};
    req1_din   = {$urandom, $urandom};
    res0_ready = 1'($urandom_range(0, 1));
    res1_ready = 1'($urandom_range(0, 1));
    dp_on      = ($urandom_range(0, 9) != 0);
  endtask

  task automatic idle_inputs();
    req0_valid = 0;
    req1_valid = 0;
    res0_ready = 1;
    res1_ready = 1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int t, n0, nres, c0, c1;
    rst_n = 0;
    req0_valid = 0; req0_flag = 0; req0_din = 64'h0;
    req1_valid = 0; req1_flag = 0; req1_din = 64'h0;
    res0_ready = 0; res1_ready = 0;
    core_dout = 64'h0; core_dout_en = 0;
    model_reset();

    // Reset state
    tick();
    chk_en = 1;
    tick();
    checkOutput("rst_job_cnt", 64'(job_cnt), 64'd0);
    rst_n = 1;
    tick();

    // Single encrypt from client 0
    $display("[TB] single encrypt");
    dp_const = 1;
    req0_flag = 1; req0_din = 64'h0123456789ABCDEF; req0_valid = 1;
    wait_accept("t1_accept");
    t = acc_cyc[$];
    req0_valid = 0;
    checkOutput("t1_din_en", 64'(core_din_en), 64'd1);
    checkOutput("t1_core_flag", 64'(core_flag), 64'd1);
    checkOutput("t1_core_din", core_din, 64'h0123456789ABCDEF);
    while (cyc < t + 13) tick();
    checkOutput("t1_res_valid", 64'(res0_valid), 64'd1);
    checkOutput("t1_res_dout", res0_dout, 64'hDEADBEEF00000001);
    checkOutput("t1_res_err", 64'(res0_err), 64'd0);
    checkOutput("t1_job_cnt", 64'(job_cnt), 64'd1);
    checkOutput("t1_res_cycle", 64'(res_cyc[$]), 64'(t + 13));
    dp_const = 0;
    res0_ready = 1;
    tick();
    res0_ready = 0;
    tick();

    // Timeout on client 1 with a late stray strobe
    $display("[TB] timeout");
    dp_on = 0;
    req1_flag = 0; req1_din = {$urandom, $urandom}; res1_ready = 1; req1_valid = 1;
    wait_accept("to_accept");
    t = acc_cyc[$];
    req1_valid = 0;
    stray_cyc = t + 20;
    while (cyc < t + 18) tick();
    checkOutput("to_res_valid", 64'(res1_valid), 64'd1);
    checkOutput("to_res_err", 64'(res1_err), 64'd1);
    checkOutput("to_res_dout", res1_dout, 64'h0);
    checkOutput("to_res_cycle", 64'(res_cyc[$]), 64'(t + 2 + TIMEOUT));
    nres = res_cyc.size();
    while (cyc < t + 24) tick();
    checkOutput("to_stray_busy", 64'(busy), 64'd0);
    checkOutput("to_stray_cnt", 64'(job_cnt), 64'd2);
    checkOutput("to_stray_nores", 64'(res_cyc.size()), 64'(nres));
    dp_on = 1;
    stray_cyc = -1;

    // Reset in the middle of WAIT
    $display("[TB] reset mid-wait");
    req0_din = {$urandom, $urandom}; req0_valid = 1;
    wait_accept("rst_accept");
    t = acc_cyc[$];
    req0_valid = 0;
    nres = res_cyc.size();
    while (cyc < t + 5) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_cnt", 64'(job_cnt), 64'd0);
    checkOutput("rst_core_din", core_din, 64'h0);
    run(14);
    checkOutput("rst_no_result", 64'(res_cyc.size()), 64'(nres));

    // Continuous tie with immediate pops
    $display("[TB] tie");
    n0 = acc_cyc.size();
    req0_valid = 1; req1_valid = 1; res0_ready = 1; res1_ready = 1;
    c0 = 0;
    while (acc_cyc.size() < n0 + 4 && c0 < 100) begin
      tick();
      c0++;
    end
    checkOutput("tie_four_accepts", 64'(acc_cyc.size() >= n0 + 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("tie_client_%0d", i), 64'(acc_cli[n0 + i]), 64'(i % 2));
      checkOutput($sformatf("tie_cycle_%0d", i), 64'(acc_cyc[n0 + i]), 64'(acc_cyc[n0] + 13 * i));
    end
    idle_inputs();
    run(30);

    // Backpressure on client 0
    $display("[TB] backpressure");
    res0_ready = 0; res1_ready = 1; req0_valid = 1; req1_valid = 1;
    n0 = acc_cyc.size();
    run(100);
    c0 = 0;
    c1 = 0;
    for (int i = n0; i < acc_cyc.size(); i++) begin
      if (acc_cli[i] == 0) c0++;
      else                 c1++;
    end
    checkOutput("bp_c0_once", 64'(c0), 64'd1);
    checkOutput("bp_c1_served", 64'(c1 >= 5), 64'd1);
    res0_ready = 1;
    tick();
    res0_ready = 0;
    wait_accept("bp_after_pop");
    checkOutput("bp_c0_next", 64'(acc_cli[$]), 64'd0);
    idle_inputs();
    run(40);

    // Job counter wrap
    $display("[TB] counter wrap");
    force dut.job_cnt = 16'hFFFF;
    #1;
    release dut.job_cnt;
    m_cnt = 16'hFFFF;
    checkOutput("wrap_preload", 64'(job_cnt), 64'hFFFF);
    req0_flag = 1; req0_din = {$urandom, $urandom}; req0_valid = 1;
    wait_accept("wrap_accept");
    t = acc_cyc[$];
    req0_valid = 0;
    while (cyc < t + 13) tick();
    checkOutput("wrap_zero", 64'(job_cnt), 64'h0);
    checkOutput("wrap_res_cycle", 64'(res_cyc[$]), 64'(t + 13));
    run(4);

    // Randomized traffic against the model
    $display("[TB] random traffic");
    stray_rand = 1;
    repeat (3000) begin
      applyStimulus();
      tick();
    end
    stray_rand = 0;
    rst_n = 1;
    dp_on = 1;
    idle_inputs();
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
